// File: rtl/seq_div.sv
// Sequential radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Fixed WIDTH-cycle iteration with RISC-V divide-by-zero and signed-overflow results.
module seq_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             vld,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvsr_mag;
    logic [WIDTH-1:0] dvnd_raw;
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;
    logic             ovf;

    logic             accept;
    logic             last_iter;

    logic             dvnd_neg;
    logic             dvsr_neg;
    logic [WIDTH-1:0] dvnd_mag_in;
    logic [WIDTH-1:0] dvsr_mag_in;
    logic             ovf_in;

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic [WIDTH:0]   rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    logic [WIDTH-1:0] quo_res;
    logic [WIDTH-1:0] rem_res;

    assign accept    = start && (state == IDLE || state == DONE);
    assign last_iter = (state == CALC) && (cnt == CW'(WIDTH - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = CALC;
            CALC: if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
            DONE: state_nxt = start ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        vld  = 1'b0;
        unique case (state)
            CALC:    busy = 1'b1;
            DONE:    vld  = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand conditioning at accept time
    // ------------------------------------------------------------------
    // Unsigned operands are taken as-is; 0x80..0 negates to itself, which is the
    // correct magnitude when read as unsigned.
    always_comb begin
        dvnd_neg    = is_signed & dividend[WIDTH-1];
        dvsr_neg    = is_signed & divisor[WIDTH-1];
        dvnd_mag_in = dvnd_neg ? -dividend : dividend;
        dvsr_mag_in = dvsr_neg ? -divisor  : divisor;
        ovf_in      = is_signed
                      && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                      && (divisor == {WIDTH{1'b1}});
    end

    // ------------------------------------------------------------------
    // One restoring iteration: shift {r,q} left, trial-subtract the divisor
    // ------------------------------------------------------------------
    always_comb begin
        shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, dvsr_mag};
        if (!diff[WIDTH+1]) begin
            rem_nxt = diff[WIDTH:0];
            quo_nxt = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = shifted;
            quo_nxt = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    // ------------------------------------------------------------------
    // Final result selection, applied to the last iteration's output
    // ------------------------------------------------------------------
    always_comb begin
        if (div_zero) begin
            quo_res = {WIDTH{1'b1}};
            rem_res = dvnd_raw;
        end else if (ovf) begin
            quo_res = {1'b1, {(WIDTH-1){1'b0}}};
            rem_res = '0;
        end else begin
            quo_res = neg_q ? -quo_nxt : quo_nxt;
            rem_res = neg_r ? -rem_nxt[WIDTH-1:0] : rem_nxt[WIDTH-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_mag  <= '0;
            dvnd_raw  <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            div_zero  <= 1'b0;
            ovf       <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            if (accept) begin
                cnt      <= '0;
                rem_q    <= '0;
                quo_q    <= dvnd_mag_in;
                dvsr_mag <= dvsr_mag_in;
                dvnd_raw <= dividend;
                neg_q    <= dvnd_neg ^ dvsr_neg;
                neg_r    <= dvnd_neg;
                div_zero <= (divisor == '0);
                ovf      <= ovf_in;
            end else if (state == CALC) begin
                cnt   <= cnt + CW'(1);
                rem_q <= rem_nxt;
                quo_q <= quo_nxt;
            end

            // Results change only on entry to DONE and hold until the next one.
            if (last_iter) begin
                quotient  <= quo_res;
                remainder <= rem_res;
            end
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: a reference model fills a scoreboard queue at
// each accepted start, and a monitor pops and compares on every vld pulse.
module tb_seq_div;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         vld;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
    } exp_t;

    exp_t sb[$];

    seq_div #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .vld       (vld),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    // RISC-V M-extension reference semantics
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sgn);
        exp_t e;
        int   sa;
        int   sb_i;
        sa   = a;
        sb_i = b;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = '0;
        end else if (sgn) begin
            e.q = sa / sb_i;
            e.r = sa % sb_i;
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst !== 1'b1 && vld === 1'b1) begin
            n_assert++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_vld: got vld=1, required no pending operation");
            end else begin
                e = sb.pop_front();
                if (quotient !== e.q) begin
                    n_fail++;
                    $display("FAIL sb_quotient: got %h, required %h", quotient, e.q);
                end
                n_assert++;
                if (remainder !== e.r) begin
                    n_fail++;
                    $display("FAIL sb_remainder: got %h, required %h", remainder, e.r);
                end
            end
        end
    end

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sgn, input bit expect_result);
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = sgn;
        start     = 1'b1;
        if (expect_result) sb.push_back(model(a, b, sgn));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_vld(input string name, input int exp_lat);
        int lat;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (vld === 1'b1) begin
                lat = i;
                break;
            end
        end
        n_assert++;
        if (lat != exp_lat) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles (0 = timeout), required %0d", name, lat, exp_lat);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sgn, input string name);
        start_op(a, b, sgn, 1'b1);
        wait_vld(name, 33);
    endtask

    task automatic expect_qr(input string name, input logic [W-1:0] q, input logic [W-1:0] r);
        n_assert++;
        if (quotient !== q || remainder !== r) begin
            n_fail++;
            $display("FAIL %s: got q=%h r=%h, required q=%h r=%h", name, quotient, remainder, q, r);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_assert++;
        if (busy !== 1'b0 || vld !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got busy=%b vld=%b, required 0 0", busy, vld);
        end
        expect_qr("reset_outputs", '0, '0);
        rst = 1'b0;
        @(negedge clk);
        n_assert++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_unsigned_timing();
        @(negedge clk);
        dividend  = 32'd100;
        divisor   = 32'd7;
        is_signed = 1'b0;
        start     = 1'b1;
        sb.push_back(model(32'd100, 32'd7, 1'b0));
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 34; cyc++) begin
            @(negedge clk);
            n_assert++;
            if (busy !== (cyc <= 32) || vld !== (cyc == 33)) begin
                n_fail++;
                $display("FAIL timing_cycle_%0d: got busy=%b vld=%b, required busy=%b vld=%b",
                         cyc, busy, vld, cyc <= 32, cyc == 33);
            end
            if (cyc == 33) expect_qr("udiv_100_7", 32'd14, 32'd2);
            if (cyc == 34) expect_qr("udiv_hold", 32'd14, 32'd2);
        end
    endtask

    task automatic test_signed();
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, "sdiv_m7_2");
        expect_qr("sdiv_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, "sdiv_7_m2");
        expect_qr("sdiv_7_m2", 32'hFFFF_FFFD, 32'd1);
        run_op(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, "sdiv_m7_m2");
        expect_qr("sdiv_m7_m2", 32'd3, 32'hFFFF_FFFF);
    endtask

    task automatic test_div_zero();
        run_op(32'd5, 32'd0, 1'b1, "divz_signed");
        expect_qr("divz_signed", 32'hFFFF_FFFF, 32'd5);
        run_op(32'd5, 32'd0, 1'b0, "divz_unsigned");
        expect_qr("divz_unsigned", 32'hFFFF_FFFF, 32'd5);
        run_op(32'hFFFF_FFF9, 32'd0, 1'b1, "divz_neg");
        expect_qr("divz_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF9);
    endtask

    task automatic test_overflow();
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "ovf_signed");
        expect_qr("ovf_signed", 32'h8000_0000, 32'd0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "ovf_unsigned");
        expect_qr("ovf_unsigned", 32'd0, 32'h8000_0000);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        dividend  = 32'd1000;
        divisor   = 32'd7;
        is_signed = 1'b0;
        start     = 1'b1;
        sb.push_back(model(32'd1000, 32'd7, 1'b0));
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 33; cyc++) begin
            @(negedge clk);
            if (cyc == 10) begin
                dividend = 32'd9;
                divisor  = 32'd3;
                start    = 1'b1;
            end else if (cyc == 11) begin
                start = 1'b0;
            end
        end
        n_assert++;
        if (vld !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_start_ignored: got vld=%b at cycle 33, required 1", vld);
        end
        expect_qr("busy_start_ignored", 32'd142, 32'd6);
        // Start during the DONE cycle
        dividend  = 32'd9;
        divisor   = 32'd3;
        is_signed = 1'b0;
        start     = 1'b1;
        sb.push_back(model(32'd9, 32'd3, 1'b0));
        @(posedge clk);
        #1 start = 1'b0;
        n_assert++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_no_gap: got busy=%b, required 1", busy);
        end
        wait_vld("b2b_second", 33);
        expect_qr("b2b_9_3", 32'd3, 32'd0);
    endtask

    task automatic test_rst_mid_op();
        int vld_hits;
        start_op(32'd1000, 32'd3, 1'b0, 1'b0);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_assert++;
        if (busy !== 1'b0 || vld !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_abort_flags: got busy=%b vld=%b, required 0 0", busy, vld);
        end
        expect_qr("rst_abort_outputs", '0, '0);
        rst = 1'b0;
        vld_hits = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (vld === 1'b1) vld_hits++;
        end
        n_assert++;
        if (vld_hits != 0) begin
            n_fail++;
            $display("FAIL rst_no_vld: got %0d vld pulses, required 0", vld_hits);
        end
        run_op(32'd1000, 32'd3, 1'b0, "after_rst");
        expect_qr("after_rst", 32'd333, 32'd1);
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            b = (i % 3 == 0) ? W'($urandom_range(1, 15)) : W'($urandom);
            run_op(a, b, logic'(i % 2), "random");
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_timing();
        test_signed();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_rst_mid_op();
        test_random();
        repeat (2) @(negedge clk);
        n_assert++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending results, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
